// File: rtl/w_74hc_pkg.sv
// Shared types for the 74HC595/74HC165 lab blocks: default width, byte payload
// and the decoded per-cycle shift-register operation.
package w_74hc_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef logic [WIDTH_DEFAULT-1:0] byte_t;

    typedef enum logic [1:0] {
        SR_HOLD  = 2'd0,
        SR_SHIFT = 2'd1,
        SR_CLEAR = 2'd2
    } sr_op_t;

    // Clear has priority over shift.
    function automatic sr_op_t decode_sr_op(input logic srclr_n, input logic shift_en);
        if (!srclr_n) begin
            return SR_CLEAR;
        end
        if (shift_en) begin
            return SR_SHIFT;
        end
        return SR_HOLD;
    endfunction

endpackage

// File: rtl/w_74hc595_if.sv
// Serial-link bus for the 74HC595-style receiver: control strobes in,
// cascade/frame status out. Parallel Q stays a plain port on the top.
interface w_74hc595_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
);
    logic             ser;
    logic             shift_en;
    logic             rclk_en;
    logic             srclr_n;
    logic             oe_n;
    logic             qh_s;
    logic             frame_done;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output ser, shift_en, rclk_en, srclr_n, oe_n,
        input  qh_s, frame_done, bit_cnt
    );

    modport slave (
        input  ser, shift_en, rclk_en, srclr_n, oe_n,
        output qh_s, frame_done, bit_cnt
    );
endinterface

// File: rtl/w_74hc_bitcnt.sv
// Frame bit counter: counts accepted shifts, wraps after WIDTH and pulses done
// for one cycle on the wrap. Shared with the parallel-to-serial transmitter.
module w_74hc_bitcnt
    import w_74hc_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  sr_op_t           op,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic at_last_c;

    assign at_last_c = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            case (op)
                SR_CLEAR: begin
                    cnt  <= '0;
                    done <= 1'b0;
                end
                SR_SHIFT: begin
                    cnt  <= at_last_c ? '0 : cnt + CNT_W'(1);
                    done <= at_last_c;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/w_74hc595.sv
// 74HC595-style serial-in/parallel-out shift register with storage latch,
// tristate outputs and frame counter. Define W_74HC595_AUTO_LATCH_EN to also
// latch each completed frame automatically on the frame_done cycle.
module w_74hc595
    import w_74hc_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    w_74hc595_if.slave       bus,
    output wire  [WIDTH-1:0] Q
);
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] store;
    sr_op_t           sr_op;
    logic             load_c;
    logic             frame_done;
    logic [CNT_W-1:0] bit_cnt;

    always_comb begin
        sr_op = decode_sr_op(bus.srclr_n, bus.shift_en);
    end

    // Storage load strobe; the auto path sees sr already holding the last bit.
    always_comb begin
        load_c = bus.rclk_en;
`ifdef W_74HC595_AUTO_LATCH_EN
        load_c = bus.rclk_en | frame_done;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            case (sr_op)
                SR_CLEAR: sr <= '0;
                SR_SHIFT: sr <= {sr[WIDTH-2:0], bus.ser};
                default:  sr <= sr;
            endcase
        end
    end

    // Latch reads pre-edge sr, giving the one-behind capture on a shared cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store <= '0;
        end else if (load_c) begin
            store <= sr;
        end
    end

    w_74hc_bitcnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bitcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .op    (sr_op),
        .cnt   (bit_cnt),
        .done  (frame_done)
    );

    assign bus.qh_s       = sr[WIDTH-1];
    assign bus.frame_done = frame_done;
    assign bus.bit_cnt    = bit_cnt;
    assign Q              = bus.oe_n ? {WIDTH{1'bz}} : store;
endmodule

// File: tb/tb_w_74hc595.sv
// Directed bench for w_74hc595: reset, frame shift/latch, one-behind latch,
// clear priority, output enable and the optional auto-latch path.
module tb_w_74hc595;
    import w_74hc_pkg::*;

    logic       clk;
    logic       rst_n;
    wire  [7:0] q;
    int         n_assert;
    int         n_fail;
    int         pulses;
    byte_t      exp_sr;
    byte_t      pat;

    w_74hc595_if #(.WIDTH(8)) bus ();

    w_74hc595 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .Q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic shift_bit(input logic b);
        bus.ser      = b;
        bus.shift_en = 1'b1;
        tick();
        bus.shift_en = 1'b0;
        exp_sr       = {exp_sr[6:0], b};
    endtask

    task automatic latch();
        bus.rclk_en = 1'b1;
        tick();
        bus.rclk_en = 1'b0;
    endtask

    // Shift a byte MSB-first, counting frame_done pulses.
    task automatic shift_byte(input byte_t v);
        for (int i = 7; i >= 0; i--) begin
            shift_bit(v[i]);
            if (bus.frame_done === 1'b1) pulses++;
        end
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        pulses       = 0;
        exp_sr       = '0;
        rst_n        = 1'b0;
        bus.ser      = 1'b0;
        bus.shift_en = 1'b0;
        bus.rclk_en  = 1'b0;
        bus.srclr_n  = 1'b1;
        bus.oe_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1. Build non-zero state, then reset asynchronously mid-cycle
        shift_byte(8'hFF);
        for (int i = 0; i < 3; i++) shift_bit(1'b1);
        latch();
        check("pre_rst_q", 32'(q), 32'h00FF);
        check("pre_rst_cnt", 32'(bus.bit_cnt), 32'd3);
        check("pre_rst_qh", 32'(bus.qh_s), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_q", 32'(q), 32'h0000);
        check("rst_qh", 32'(bus.qh_s), 32'd0);
        check("rst_cnt", 32'(bus.bit_cnt), 32'd0);
        check("rst_fd", 32'(bus.frame_done), 32'd0);
        rst_n  = 1'b1;
        exp_sr = '0;
        tick();

        // 2. Shift A5 MSB-first, watching qh_s, counter and frame_done
        pat    = 8'hA5;
        pulses = 0;
        for (int i = 7; i >= 0; i--) begin
            shift_bit(pat[i]);
            check("a5_qh", 32'(bus.qh_s), 32'(exp_sr[7]));
            check("a5_cnt", 32'(bus.bit_cnt), 32'((8 - i) % 8));
            check("a5_fd", 32'(bus.frame_done), (i == 0) ? 32'd1 : 32'd0);
        end
        check("a5_q_prelatch", 32'(q), 32'h0000);
        latch();
        check("a5_q", 32'(q), 32'h00A5);
        check("a5_fd_clear", 32'(bus.frame_done), 32'd0);

        // 3. Latch and shift together capture pre-shift sr
        shift_byte(8'h3C);
        bus.ser      = 1'b1;
        bus.shift_en = 1'b1;
        bus.rclk_en  = 1'b1;
        tick();
        bus.shift_en = 1'b0;
        bus.rclk_en  = 1'b0;
        check("onebehind_q", 32'(q), 32'h003C);
        check("onebehind_qh", 32'(bus.qh_s), 32'd0);
        check("onebehind_cnt", 32'(bus.bit_cnt), 32'd1);
        latch();
        check("onebehind_sr", 32'(q), 32'h0079);

        // 4. Clear beats shift; a gap holds the count
        bus.srclr_n = 1'b0;
        tick();
        bus.srclr_n = 1'b1;
        check("clr_cnt0", 32'(bus.bit_cnt), 32'd0);
        for (int i = 0; i < 5; i++) shift_bit(1'b1);
        repeat (3) tick();
        check("gap_cnt", 32'(bus.bit_cnt), 32'd5);
        bus.srclr_n  = 1'b0;
        bus.shift_en = 1'b1;
        bus.ser      = 1'b1;
        tick();
        bus.srclr_n  = 1'b1;
        bus.shift_en = 1'b0;
        check("clr_cnt", 32'(bus.bit_cnt), 32'd0);
        check("clr_fd", 32'(bus.frame_done), 32'd0);
        check("clr_qh", 32'(bus.qh_s), 32'd0);
        latch();
        check("clr_sr", 32'(q), 32'h0000);
        pulses = 0;
        shift_byte(8'h96);
        tick();
        check("post_clr_pulses", 32'(pulses), 32'd1);
        latch();
        check("post_clr_q", 32'(q), 32'h0096);

        // 5. Output enable only gates the drivers
        shift_byte(8'hFF);
        latch();
        check("oe_on", 32'(q), 32'h00FF);
        bus.oe_n = 1'b1;
        #1;
        n_assert++;
        assert (q === 8'hzz) else begin
            n_fail++;
            $error("FAIL oe_off: observed %h expected zz", q);
        end
        tick();
        bus.oe_n = 1'b0;
        #1;
        check("oe_back", 32'(q), 32'h00FF);
        bus.oe_n = 1'b1;
        tick();
        n_assert++;
        assert (q === 8'hzz) else begin
            n_fail++;
            $error("FAIL oe_off2: observed %h expected zz", q);
        end
        bus.oe_n = 1'b0;
        #1;
        check("oe_store_kept", 32'(q), 32'h00FF);

        // 6. Frames shifted with rclk_en low
        pulses = 0;
        shift_byte(8'h5A);
        check("auto_fd", 32'(bus.frame_done), 32'd1);
        check("auto_q_e8", 32'(q), 32'h00FF);
`ifdef W_74HC595_AUTO_LATCH_EN
        shift_bit(1'b1);
        check("auto_q_5a", 32'(q), 32'h005A);
        pat = 8'hC3;
        for (int i = 6; i >= 0; i--) shift_bit(pat[i]);
        check("auto_q_hold", 32'(q), 32'h005A);
        check("auto_fd2", 32'(bus.frame_done), 32'd1);
        tick();
        check("auto_q_c3", 32'(q), 32'h00C3);
`else
        tick();
        tick();
        check("noauto_q", 32'(q), 32'h00FF);
        latch();
        check("noauto_latch", 32'(q), 32'h005A);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
